mul_seq_ctrl: RTL and testbench
===============================

# mul_seq_ctrl

Iterative multiply sequencer that takes the 32-bit MUL operation off the single-cycle ALU critical path. It sits beside the ALU in the EX stage. When the decoder flags a MUL, it latches both operands and runs a shift-add loop over several cycles. It holds the pipeline via `Stall_o` until the product is ready, then presents the low 32 bits, bit-identical to the ALU's combinational MUL result.

## Interface
- `DATA_W`, 32: operand/result width.
- `EARLY_EXIT`, 1: 1 = terminate when remaining multiplier bits are zero; 0 = always DATA_W iterations.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `Start_i` input 1: EX stage holds a MUL; sampled only in IDLE.
- `Flush_i` input 1: pipeline flush; aborts any operation in progress.
- `Data1_i` input DATA_W: multiplicand (signed, two's complement).
- `Data2_i` input DATA_W: multiplier (signed, two's complement).
- `Stall_o` output 1: freeze PC/IF/ID/EX registers this cycle.
- `Done_o` output 1: one-cycle pulse; `Result_o` valid.
- `Result_o` output DATA_W: low DATA_W bits of Data1_i*Data2_i.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE:**
  - On `Start_i=1 & Flush_i=0`, latch `mcand<=Data1_i`, `mplier<=Data2_i`, `acc<=0`, `cnt<=0`, and go to CALC.
  - Otherwise stay in IDLE.
- **CALC, each cycle:**
  - If `mplier[0]`, then `acc<=acc+mcand` (mod 2^DATA_W).
  - Then `mcand<=mcand<<1`, `mplier<=mplier>>1` (logical), `cnt<=cnt+1`.
  - Go to DONE when `cnt==DATA_W-1`, or when `EARLY_EXIT=1` and the shifted `mplier` is 0.
- **DONE:**
  - `Result_o<=acc` is registered on entry, so it is visible during DONE.
  - `Done_o=1` for exactly this cycle.
  - Unconditional next state is IDLE.
  - `Start_i` is ignored in DONE; the instruction still in EX is the one just completed.
- **Signedness:** the low DATA_W bits of a two's-complement product equal the unsigned product of the raw bit patterns. No sign correction is performed, and no high half is produced.
- **Overflow:** silently wraps mod 2^DATA_W.
- **Iteration count N:**
  - With `EARLY_EXIT=1`: N = (index of highest set bit of Data2_i)+1, and N=1 when Data2_i=0.
  - With `EARLY_EXIT=0`: N=DATA_W.
  - Any negative Data2_i gives N=DATA_W.
- **Flush_i=1 in any state:** next state IDLE, no `Done_o`, `Result_o` unchanged. Flush has priority over Start and over loop completion.
- **Result_o:** holds the last completed result until the next DONE.

## Timing
- Cycle 0: IDLE with `Start_i=1`. Cycles 1..N: CALC. Cycle N+1: DONE. Cycle N+2: IDLE, which may accept the next MUL.
- `Stall_o` is combinational: `rst_n & ~Flush_i & ((IDLE & Start_i) | CALC)`.
  - It is 1 in cycles 0..N and 0 in the DONE cycle, so EX and the writeback register capture `Result_o` at the end of cycle N+1.
- Total latency from Start to Done is N+1 cycles. Back-to-back MUL issue interval is N+2 cycles.
- **Reset values** while `rst_n=0` (sampled at edge):
  - state=IDLE, `acc`, `mcand`, `mplier`, `cnt` = 0.
  - `Result_o`=0, `Done_o`=0.
  - `Stall_o` is forced 0 combinationally.
- **Reset mid-operation:** the next cycle is IDLE with all outputs at reset values; no `Done_o` for the aborted op.
- **Simultaneous Flush_i and Start_i in IDLE:** the start is rejected and `Stall_o`=0.

## Test plan
- 3 × 5, EARLY_EXIT=1, Start at cycle 0 -> `Stall_o`=1 in cycles 0–3; `Done_o`=1 and `Result_o`=15 (0x0000000F) in cycle 4; IDLE in cycle 5.
- −7 × 3 -> N=2; `Done_o` in cycle 3 with `Result_o`=0xFFFFFFEB. Separately, 6 × −1 -> N=32; `Done_o` in cycle 33 with `Result_o`=0xFFFFFFFA.
- 0x7FFFFFFF × 2 -> `Result_o`=0xFFFFFFFE (wrap, no flag). 0x12345678 × 0 -> N=1; `Done_o` in cycle 2 with `Result_o`=0.
- `Start_i` held high through DONE (stalled instruction) -> exactly one `Done_o` pulse, and no restart in the DONE cycle. A new Start in cycle N+2 -> a second correct product.
- -1 × -1 (0xFFFFFFFF × 0xFFFFFFFF), Start at cycle 0 -> N=32 with both EARLY_EXIT values; `Done_o` at cycle 33 with `Result_o`=0x00000001.
- Interrupt cases:
  - `Flush_i`=1 at cycle 5 of a 32-iteration op -> IDLE at cycle 6, no `Done_o`, `Result_o` keeps its prior value, and `Stall_o`=0 from cycle 5.
  - `rst_n`=0 at cycle 10 -> all outputs 0 from the next cycle. The next op after reset completes correctly.

Source files
------------

// File: rtl/mul_seq_ctrl_if.sv
// Handshake bundle between the EX stage and the iterative multiply sequencer.
// Start_i is sampled only while the sequencer is idle; Done_o is a one-cycle pulse that qualifies Result_o.
interface mul_seq_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              Start_i;
    logic              Flush_i;
    logic [DATA_W-1:0] Data1_i;
    logic [DATA_W-1:0] Data2_i;
    logic              Stall_o;
    logic              Done_o;
    logic [DATA_W-1:0] Result_o;

    modport master (
        output Start_i, Flush_i, Data1_i, Data2_i,
        input  Stall_o, Done_o, Result_o
    );

    modport slave (
        input  Start_i, Flush_i, Data1_i, Data2_i,
        output Stall_o, Done_o, Result_o
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-add multiply sequencer beside the EX-stage ALU; stalls the pipeline
// until the low DATA_W bits of Data1_i*Data2_i are ready.
module mul_seq_ctrl #(
    parameter int DATA_W     = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    mul_seq_ctrl_if.slave bus,
    output logic [1:0]   dbg_state_o
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] acc_sum;
    logic [DATA_W-1:0] mplier_sh;
    logic              last_iter;

    always_comb begin
        acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_sh = mplier_q >> 1;
        last_iter = (cnt_q == CNT_LAST) || (EARLY_EXIT && (mplier_sh == '0));
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (bus.Start_i && !bus.Flush_i) begin
                    mcand_d  = bus.Data1_i;
                    mplier_d = bus.Data2_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_sh;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    // Capture includes this cycle's partial product.
                    result_d = acc_sum;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush outranks both a new start and loop completion.
        if (bus.Flush_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.Stall_o  = rst_n & ~bus.Flush_i &
                          (((state_q == IDLE) & bus.Start_i) | (state_q == CALC));
    assign bus.Done_o   = (state_q == DONE);
    assign bus.Result_o = result_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: drivers queue expected products and done
// cycles, monitors pop and compare whenever Done_o pulses.
module tb_mul_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_seq_ctrl_if #(.DATA_W(32)) bus ();
    mul_seq_ctrl_if #(.DATA_W(32)) bus_f ();
    logic [1:0] st, st_f;

    mul_seq_ctrl #(.DATA_W(32), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .dbg_state_o(st)
    );
    mul_seq_ctrl #(.DATA_W(32), .EARLY_EXIT(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .bus(bus_f.slave), .dbg_state_o(st_f)
    );

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    logic [31:0] exp_q[$];
    int          expc_q[$];
    logic [31:0] expf_q[$];
    int          expfc_q[$];
    logic [31:0] last_res;
    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    logic [31:0] m_e, mf_e;
    int          m_c, mf_c;
    always @(negedge clk) begin
        #2;
        if (bus.Done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got Done_o=1 want 0 (cycle %0d)", cyc);
            end else begin
                m_e = exp_q.pop_front();
                m_c = expc_q.pop_front();
                chk("result", bus.Result_o, m_e);
                chk("done_cycle", 32'(cyc), 32'(m_c));
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (bus_f.Done_o === 1'b1) begin
            if (expf_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done_full: got Done_o=1 want 0 (cycle %0d)", cyc);
            end else begin
                mf_e = expf_q.pop_front();
                mf_c = expfc_q.pop_front();
                chk("result_full", bus_f.Result_o, mf_e);
                chk("done_cycle_full", 32'(cyc), 32'(mf_c));
            end
        end
    end

    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] e, input bit hold);
        @(negedge clk);
        bus.Start_i = 1'b1;
        bus.Data1_i = a;
        bus.Data2_i = b;
        exp_q.push_back(e);
        expc_q.push_back(cyc + n + 1);
        last_res = e;
        #1 chk("stall_issue", 32'(bus.Stall_o), 32'd1);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (!hold) bus.Start_i = 1'b0;
            bus.Data1_i = $urandom;
            bus.Data2_i = $urandom;
            #1 chk("stall_calc", 32'(bus.Stall_o), 32'd1);
        end
        @(negedge clk);
        #1;
        chk("stall_done", 32'(bus.Stall_o), 32'd0);
        chk("state_done", 32'(st), 32'd2);
    endtask

    task automatic do_mul_f(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        @(negedge clk);
        bus_f.Start_i = 1'b1;
        bus_f.Data1_i = a;
        bus_f.Data2_i = b;
        expf_q.push_back(e);
        expfc_q.push_back(cyc + 33);
        #1 chk("stall_issue_full", 32'(bus_f.Stall_o), 32'd1);
        @(negedge clk);
        bus_f.Start_i = 1'b0;
        repeat (33) @(negedge clk);
    endtask

    initial begin
        bus.Start_i = 1'b1; bus.Flush_i = 1'b0; bus.Data1_i = '0; bus.Data2_i = '0;
        bus_f.Start_i = 1'b0; bus_f.Flush_i = 1'b0; bus_f.Data1_i = '0; bus_f.Data2_i = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall_forced", 32'(bus.Stall_o), 32'd0);
        chk("rst_result", bus.Result_o, 32'd0);
        chk("rst_done", 32'(bus.Done_o), 32'd0);
        chk("rst_state", 32'(st), 32'd0);
        bus.Start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(32'd3,          32'd5,          3,  32'h0000000F, 1'b0);
        do_mul(32'hFFFFFFF9,   32'd3,          2,  32'hFFFFFFEB, 1'b0);
        do_mul(32'd6,          32'hFFFFFFFF,   32, 32'hFFFFFFFA, 1'b0);
        do_mul(32'h7FFFFFFF,   32'd2,          2,  32'hFFFFFFFE, 1'b0);
        do_mul(32'h12345678,   32'd0,          1,  32'h00000000, 1'b0);
        do_mul(32'hFFFFFFFF,   32'hFFFFFFFF,   32, 32'h00000001, 1'b0);
        do_mul(32'h00010000,   32'h00010000,   17, 32'h00000000, 1'b0);

        // Start held through DONE, then a back-to-back issue at N+2.
        do_mul(32'h00001234,   32'h00000010,   5,  32'h00012340, 1'b1);
        do_mul(32'h0000ABCD,   32'd3,          2,  32'h00020367, 1'b1);
        @(negedge clk);
        bus.Start_i = 1'b0;
        #1;
        chk("no_restart_state", 32'(st), 32'd0);
        chk("no_restart_stall", 32'(bus.Stall_o), 32'd0);

        // Flush together with Start in IDLE rejects the start.
        @(negedge clk);
        bus.Start_i = 1'b1; bus.Flush_i = 1'b1;
        bus.Data1_i = 32'd9; bus.Data2_i = 32'd9;
        #1 chk("flush_start_stall", 32'(bus.Stall_o), 32'd0);
        @(negedge clk);
        bus.Start_i = 1'b0; bus.Flush_i = 1'b0;
        #1 chk("flush_start_state", 32'(st), 32'd0);

        // Flush five cycles into a 32-iteration op.
        @(negedge clk);
        bus.Start_i = 1'b1; bus.Data1_i = 32'd6; bus.Data2_i = 32'hFFFFFFFF;
        @(negedge clk);
        bus.Start_i = 1'b0;
        repeat (4) @(negedge clk);
        bus.Flush_i = 1'b1;
        #1 chk("flush_stall", 32'(bus.Stall_o), 32'd0);
        @(negedge clk);
        bus.Flush_i = 1'b0;
        #1;
        chk("flush_state", 32'(st), 32'd0);
        chk("flush_result_kept", bus.Result_o, last_res);
        chk("flush_stall_after", 32'(bus.Stall_o), 32'd0);
        repeat (34) @(negedge clk);

        // Reset ten cycles into a 32-iteration op.
        @(negedge clk);
        bus.Start_i = 1'b1; bus.Data1_i = 32'hFFFFFFFF; bus.Data2_i = 32'hFFFFFFFF;
        @(negedge clk);
        bus.Start_i = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1 chk("midrst_stall_forced", 32'(bus.Stall_o), 32'd0);
        @(negedge clk);
        #1;
        chk("midrst_result", bus.Result_o, 32'd0);
        chk("midrst_done", 32'(bus.Done_o), 32'd0);
        chk("midrst_state", 32'(st), 32'd0);
        rst_n = 1'b1;
        last_res = '0;
        repeat (35) @(negedge clk);
        do_mul(32'd10, 32'd10, 4, 32'd100, 1'b0);

        do_mul_f(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        do_mul_f(32'd3,        32'd5,        32'h0000000F);

        repeat (2) @(negedge clk);
        for (int i = 0; i < 100 && (exp_q.size() != 0 || expf_q.size() != 0); i++)
            @(negedge clk);
        chk("drain_pending", 32'(exp_q.size() + expf_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
